// File: rtl/spi_sensor_pkg.sv
// spi_sensor_slave shared types and defaults.
// Imported by the interface, the synchronizer and the top level.
package spi_sensor_pkg;

    localparam int SPI_DATA_W      = 16;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sensor_slave_if.sv
// Pin bundle of the emulated SPI sensor: producer side and SPI side.
// The slave modport is the responder, master is the board/bench.
interface spi_sensor_slave_if
    import spi_sensor_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
);
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              sample_ready;
    logic              sclk;
    logic              cs;
    logic              miso;
    logic              busy;
    logic              frame_done;
    logic              frame_abort;
    logic              frame_stale;

    modport slave (
        input  sample_data,
        input  sample_valid,
        input  sclk,
        input  cs,
        output sample_ready,
        output miso,
        output busy,
        output frame_done,
        output frame_abort,
        output frame_stale
    );

    modport master (
        output sample_data,
        output sample_valid,
        output sclk,
        output cs,
        input  sample_ready,
        input  miso,
        input  busy,
        input  frame_done,
        input  frame_abort,
        input  frame_stale
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with rise/fall pulses.
// Edges are held off until the chain has filled with real pin samples.
module spi_sync_edge
    import spi_sensor_pkg::*;
#(
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [SYNC_STAGES:0]   r_fill;
    logic                   w_filled;

    // Synchronizer chain, one delayed copy for edge detection, fill tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_fill <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // A pin already low at reset release must not look like a falling edge.
    assign w_filled = r_fill[SYNC_STAGES];
    assign o_rise   = w_filled &  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall   = w_filled & ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule

// File: rtl/spi_sensor_slave.sv
// SPI responder emulating a 16-bit read-only sensor (CPOL=0, MSB first).
// Holds the latest producer sample and shifts it out on each cs frame.
module spi_sensor_slave
    import spi_sensor_pkg::*;
#(
    parameter int                DATA_W       = SPI_DATA_W,
    parameter int                SYNC_STAGES  = SPI_SYNC_STAGES,
    parameter logic [DATA_W-1:0] RESET_SAMPLE = '0
) (
    input logic               clk,
    input logic               rst_n,
    spi_sensor_slave_if.slave bus
);

    localparam int CW = $clog2(DATA_W + 1);

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_rise;
    logic w_cs_fall;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_pending;
    logic              r_fresh;
    logic              w_fresh_nxt;
    logic [DATA_W-2:0] r_shift;
    logic [DATA_W-2:0] w_shift_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [CW-1:0]     w_cnt_inc;
    logic              r_miso;
    logic              w_miso_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_abort;
    logic              w_abort_nxt;
    logic              r_stale;
    logic              w_stale_nxt;
    logic              r_ready;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sclk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_pin  (bus.sclk),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_pin  (bus.cs),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    // Pending sample: last write wins, independent of frame activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= RESET_SAMPLE;
        end else if (bus.sample_valid) begin
            r_pending <= bus.sample_data;
        end
    end

    // State and frame datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_fresh <= 1'b0;
            r_shift <= '0;
            r_cnt   <= '0;
            r_miso  <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            r_stale <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fresh <= w_fresh_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_miso  <= w_miso_nxt;
            r_done  <= w_done_nxt;
            r_abort <= w_abort_nxt;
            r_stale <= w_stale_nxt;
            r_ready <= 1'b1;
        end
    end

    // Next state and datapath; cs rise outranks any sclk edge.
    always_comb begin
        w_state_nxt = r_state;
        w_fresh_nxt = r_fresh;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_miso_nxt  = r_miso;
        w_done_nxt  = 1'b0;
        w_abort_nxt = 1'b0;
        w_stale_nxt = r_stale;
        w_cnt_inc   = r_cnt + CW'(1);

        unique case (r_state)
            ST_IDLE: begin
                w_miso_nxt = 1'b0;
                if (w_cs_fall) begin
                    w_shift_nxt = r_pending[DATA_W-2:0];
                    w_stale_nxt = ~r_fresh;
                    w_fresh_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    w_miso_nxt  = r_pending[DATA_W-1];
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_cs_rise) begin
                    w_abort_nxt = 1'b1;
                    w_miso_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (w_sclk_rise) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == CW'(DATA_W)) begin
                        w_done_nxt  = 1'b1;
                        w_miso_nxt  = 1'b0;
                        w_state_nxt = ST_DONE;
                    end
                end else if (w_sclk_fall) begin
                    w_miso_nxt  = r_shift[DATA_W-2];
                    w_shift_nxt = {r_shift[DATA_W-3:0], 1'b0};
                end
            end
            ST_DONE: begin
                w_miso_nxt = 1'b0;
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_miso_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A write racing a frame start still marks the new value as fresh.
        if (bus.sample_valid) begin
            w_fresh_nxt = 1'b1;
        end
    end

    assign bus.sample_ready = r_ready;
    assign bus.miso         = r_miso;
    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.frame_done   = r_done;
    assign bus.frame_abort  = r_abort;
    assign bus.frame_stale  = r_stale;

endmodule

// File: tb/tb_spi_sensor_slave.sv
// Randomized bench for spi_sensor_slave against a frame-level model.
// The model tracks only the pending value and its freshness.
module tb_spi_sensor_slave;

    localparam int SS = 2;
    localparam int HP = 50;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   n_done;
    int   n_abort;

    logic [15:0] pending_m;
    logic        fresh_m;

    spi_sensor_slave_if #(.DATA_W(16)) bus ();

    spi_sensor_slave #(
        .DATA_W       (16),
        .SYNC_STAGES  (SS),
        .RESET_SAMPLE (16'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters: a stuck-high pulse shows up as extra counts.
    always @(posedge clk) begin
        if (bus.frame_done === 1'b1) n_done <= n_done + 1;
        if (bus.frame_abort === 1'b1) n_abort <= n_abort + 1;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: run did not end, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_sample(input logic [15:0] d);
        @(negedge clk);
        bus.sample_data  = d;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        pending_m = d;
        fresh_m   = 1'b1;
    endtask

    task automatic sclk_cycle();
        bus.sclk = 1'b1;
        wait_clk(HP);
        bus.sclk = 1'b0;
        wait_clk(HP);
    endtask

    task automatic run_frame(input int nclk, input bit inj,
                             input logic [15:0] injd,
                             output logic [15:0] rx, output logic st,
                             output logic bad, output int blat);
        rx  = '0;
        st  = 1'b0;
        bad = 1'b0;
        @(negedge clk);
        bus.cs = 1'b0;
        if (inj) begin
            wait_clk(2);
            bus.sample_data  = injd;
            bus.sample_valid = 1'b1;
            @(negedge clk);
            bus.sample_valid = 1'b0;
            wait_clk(HP - 3);
        end else begin
            wait_clk(HP);
        end
        for (int i = 0; i < nclk; i++) begin
            if (i < 16) rx = {rx[14:0], bus.miso};
            else if (bus.miso !== 1'b0) bad = 1'b1;
            bus.sclk = 1'b1;
            wait_clk(HP);
            if (i == 0) st = bus.frame_stale;
            if (i >= 16 && bus.miso !== 1'b0) bad = 1'b1;
            bus.sclk = 1'b0;
            wait_clk(HP);
        end
        bus.cs = 1'b1;
        blat = 0;
        for (int k = 1; k <= 20 && blat == 0; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) blat = k;
        end
        wait_clk(10);
    endtask

    task automatic do_frame(input string tag, input int nclk,
                            input bit inj, input logic [15:0] injd);
        logic [15:0] exp_d;
        logic        exp_st;
        logic [15:0] rx;
        logic        st;
        logic        bad;
        int          blat;
        int          d0;
        int          a0;
        int          nb;
        d0     = n_done;
        a0     = n_abort;
        exp_d  = pending_m;
        exp_st = ~fresh_m;
        fresh_m = 1'b0;
        if (inj) begin
            pending_m = injd;
            fresh_m   = 1'b1;
        end
        run_frame(nclk, inj, injd, rx, st, bad, blat);
        nb = (nclk < 16) ? nclk : 16;
        check({tag, "_data"}, 32'(rx), 32'(exp_d >> (16 - nb)));
        check({tag, "_stale"}, 32'(st), 32'(exp_st));
        check({tag, "_done"}, 32'(n_done - d0), (nclk >= 16) ? 1 : 0);
        check({tag, "_abort"}, 32'(n_abort - a0), (nclk < 16) ? 1 : 0);
        check({tag, "_busylat"}, 32'(blat), SS + 1);
        check({tag, "_xmiso"}, 32'(bad), 0);
        check({tag, "_miso_idle"}, 32'(bus.miso), 0);
    endtask

    initial begin
        int d0;
        int a0;
        int nclk;
        n_checks = 0;
        n_pass   = 0;
        n_done   = 0;
        n_abort  = 0;
        pending_m = 16'h0000;
        fresh_m   = 1'b0;
        rst_n = 1'b0;
        bus.cs = 1'b1;
        bus.sclk = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_data = '0;
        wait_clk(4);
        check("rst_miso", 32'(bus.miso), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.frame_done), 0);
        check("rst_abort", 32'(bus.frame_abort), 0);
        check("rst_stale", 32'(bus.frame_stale), 0);
        check("rst_ready", 32'(bus.sample_ready), 0);
        rst_n = 1'b1;
        wait_clk(10);
        check("ready", 32'(bus.sample_ready), 1);

        write_sample(16'hAAAA);
        do_frame("aaaa", 16, 1'b0, 16'h0);

        write_sample(16'h1234);
        do_frame("b2b_1", 16, 1'b0, 16'h0);
        do_frame("b2b_2", 16, 1'b0, 16'h0);

        do_frame("abort7", 7, 1'b0, 16'h0);
        do_frame("post_abort", 16, 1'b0, 16'h0);

        write_sample(16'h0F0F);
        do_frame("inj", 16, 1'b1, 16'hBEEF);
        do_frame("post_inj", 16, 1'b0, 16'h0);

        write_sample(16'h5A3C);
        do_frame("extra4", 20, 1'b0, 16'h0);

        write_sample(16'hC0DE);
        d0 = n_done;
        a0 = n_abort;
        @(negedge clk);
        bus.cs = 1'b0;
        wait_clk(HP);
        for (int i = 0; i < 9; i++) sclk_cycle();
        bus.sclk = 1'b1;
        wait_clk(5);
        rst_n = 1'b0;
        wait_clk(3);
        check("mrst_miso", 32'(bus.miso), 0);
        check("mrst_busy", 32'(bus.busy), 0);
        check("mrst_stale", 32'(bus.frame_stale), 0);
        check("mrst_ready", 32'(bus.sample_ready), 0);
        pending_m = 16'h0000;
        fresh_m   = 1'b0;
        rst_n = 1'b1;
        wait_clk(HP);
        bus.sclk = 1'b0;
        wait_clk(HP);
        for (int i = 0; i < 4; i++) sclk_cycle();
        check("mrst_idle_busy", 32'(bus.busy), 0);
        check("mrst_idle_miso", 32'(bus.miso), 0);
        check("mrst_pulses", 32'((n_done - d0) + (n_abort - a0)), 0);
        bus.cs = 1'b1;
        wait_clk(20);
        check("mrst_cs_rise", 32'(n_abort - a0), 0);
        do_frame("post_rst", 16, 1'b0, 16'h0);

        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                write_sample(16'($urandom));
                if ($urandom_range(0, 3) == 0)
                    write_sample(16'($urandom));
            end
            if ($urandom_range(0, 2) == 0) nclk = $urandom_range(1, 15);
            else nclk = $urandom_range(16, 18);
            do_frame($sformatf("rnd%0d", k), nclk,
                     ($urandom_range(0, 4) == 0), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_sensor_slave.md
# spi_sensor_slave

Synthesizable SPI responder that emulates the 16-bit thermocouple sensor read by `spi_master` (CPOL=0, read-only, MSB first, active-low `cs`). It holds the most recent sample written by a parallel producer, launches it on `miso` when the master selects it, and reports frame completion or abort. It closes the loop on the data logger: board-level and FPGA self-test builds place it on the sensor pins in place of the real chip.

## Interface
- `DATA_W`, 16: frame width in bits.
- `SYNC_STAGES`, 2: synchronizer depth on `sclk` and `cs` (minimum 2).
- `RESET_SAMPLE`, 16'h0000: value of the pending register after reset.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `sample_data`  in  DATA_W  sample to present on the next frame.
- `sample_valid`  in  1  writes `sample_data` into the pending register this cycle.
- `sample_ready`  out  1  always 1 out of reset; 0 while `rst_n` is asserted.
- `sclk`  in  1  SPI clock from master, asynchronous to `clk`.
- `cs`  in  1  chip select from master, active low, asynchronous.
- `miso`  out  1  serial data to master.
- `busy`  out  1  high in SHIFT and DONE.
- `frame_done`  out  1  one-cycle pulse after the DATA_W-th `sclk` rising edge.
- `frame_abort`  out  1  one-cycle pulse when `cs` deasserts in SHIFT.
- `frame_stale`  out  1  level, valid while `busy`: the current frame's data was not refreshed since the previous frame.

## Operation
- `sclk` and `cs` each pass through SYNC_STAGES flops; edges are detected from the last two stages.
- Pending register: written whenever `sample_valid`; sets `fresh`. Overwrite without a frame is legal (last write wins).
- States: IDLE, SHIFT, DONE.
- IDLE: `miso`=0. On `cs` fall: shift register <= pending, `frame_stale` <= ~`fresh`, `fresh` <= 0, bit count <= 0, `miso` <= pending[DATA_W-1], go to SHIFT.
- SHIFT: on `sclk` rise: bit count++. If the count reaches DATA_W, pulse `frame_done` and go to DONE. On `sclk` fall: shift left, `miso` <= next bit.
- DONE: `miso`=0. Further `sclk` edges are ignored. On `cs` rise, go to IDLE.
- `cs` rise in SHIFT: pulse `frame_abort`, `miso` <= 0, go to IDLE. Data is not re-queued and `fresh` stays 0.
- Priority in one cycle: `cs` rise > `sclk` edge. A `cs` fall and a `sample_valid` write together: the frame takes the old pending value, the new value is stored, and `fresh`=1.
- The bit count is $clog2(DATA_W+1) bits wide and never wraps.

## Timing
- Reset values: `miso`=0, `busy`=0, `frame_done`=0, `frame_abort`=0, `frame_stale`=0, `sample_ready`=0, pending=RESET_SAMPLE, `fresh`=0, state IDLE. Reset mid-frame aborts silently with no pulse.
- Pin-to-response latency: SYNC_STAGES+1 `clk` cycles from a pin edge to a `miso`, state or pulse update.
- Constraint: each `sclk` half-period and the `cs`-fall-to-first-`sclk`-rise time must be at least SYNC_STAGES+3 `clk` periods. At `CLK_DIV` 100 there are 50 cycles per half-period.
- `miso` changes only after a `cs` fall or an `sclk` fall, so it is stable around every master sampling (rising) edge.
- `frame_done` asserts SYNC_STAGES+1 cycles after the last `sclk` rise, before `cs` rises.

## Structure
- Package `spi_sensor_pkg`: state enum (IDLE, SHIFT, DONE) and the DATA_W default constant.
- Sub-module `spi_sync_edge` (synchronizer plus rise/fall pulse outputs), instantiated once for `sclk` and once for `cs`.
- Top-level module: pending register, shift register, bit counter and FSM. Estimated 150–250 lines total.

## Test plan
- Write 16'hAAAA, then run a `spi_master` frame at `CLK_DIV`=100. Required: master `dout`=16'hAAAA, one `frame_done` pulse, `frame_stale`=0.
- Write 16'h1234, run two frames back to back with no write between them. Required: both read 16'h1234, `frame_stale`=0 on the first frame and 1 on the second.
- Drop `cs`, give 7 `sclk` cycles, raise `cs`. Required: one `frame_abort` pulse, no `frame_done`, `miso`=0, state IDLE. The next frame (no new write) has `frame_stale`=1.
- Pulse `sample_valid` with 16'hBEEF in the same cycle the synchronized `cs` fall is seen, with pending=16'h0F0F. Required: the frame reads 16'h0F0F, the next frame reads 16'hBEEF with `frame_stale`=0.
- Complete 16 bits, then apply 4 extra `sclk` cycles before raising `cs`. Required: `miso` stays 0, exactly one `frame_done`, `busy` falls SYNC_STAGES+1 cycles after `cs` rises.
- Assert `rst_n` low at bit 9 of a frame. Required: all outputs at their reset values, pending=RESET_SAMPLE, no pulses. After release with `cs` still low, the block waits in IDLE for a fresh `cs` fall.
